fc_per2apb: RTL and testbench

//  Peripheral-interconnect slave to APB master bridge for the FC subsystem; converse of apb2per.

---
 rtl/fc_per2apb_pkg.sv | 13 +
 rtl/fc_per2apb_tmo_cnt.sv | 31 +++
 rtl/fc_per2apb.sv | 153 +++++++++++++++
 tb/tb_fc_per2apb.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_per2apb_pkg.sv
// Shared types and constants for the peripheral-bus to APB4 bridge.
package fc_per2apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  localparam logic RESP_OK  = 1'b0;
  localparam logic RESP_ERR = 1'b1;

endpackage

// File: rtl/fc_per2apb_tmo_cnt.sv
// ACCESS-phase watchdog: counts cycles while enabled, flags the last allowed cycle.
module fc_per2apb_tmo_cnt #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_cnt;
  logic          w_expired;

  // Expired marks the TIMEOUT_CYCLES-th enabled cycle, so the abort lands on that cycle.
  assign w_expired = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign o_expired = w_expired;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && !w_expired) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/fc_per2apb.sv
// Peripheral-interconnect slave to APB4 master bridge, one transaction in flight.
// Optional ACCESS watchdog enabled by defining FC_PER2APB_TIMEOUT_EN.
module fc_per2apb
  import fc_per2apb_pkg::*;
#(
  parameter int PER_ADDR_WIDTH = 32,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int ID_WIDTH       = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      per_slave_req_i,
  input  logic [PER_ADDR_WIDTH-1:0] per_slave_add_i,
  input  logic                      per_slave_we_i,
  input  logic [31:0]               per_slave_wdata_i,
  input  logic [3:0]                per_slave_be_i,
  input  logic [ID_WIDTH-1:0]       per_slave_id_i,
  output logic                      per_slave_gnt_o,
  output logic                      per_slave_r_valid_o,
  output logic                      per_slave_r_opc_o,
  output logic [ID_WIDTH-1:0]       per_slave_r_id_o,
  output logic [31:0]               per_slave_r_rdata_o,
  output logic [APB_ADDR_WIDTH-1:0] paddr_o,
  output logic [31:0]               pwdata_o,
  output logic                      pwrite_o,
  output logic [3:0]                pstrb_o,
  output logic                      psel_o,
  output logic                      penable_o,
  input  logic [31:0]               prdata_i,
  input  logic                      pready_i,
  input  logic                      pslverr_i
);

  state_e                    r_state;
  state_e                    w_state_nxt;
  logic                      w_gnt;
  logic                      w_expired;
  logic                      w_timeout;
  logic                      w_done;
  logic                      w_psel;
  logic                      w_penable;

  logic [APB_ADDR_WIDTH-1:0] r_addr;
  logic                      r_we;
  logic [31:0]               r_wdata;
  logic [3:0]                r_be;
  logic [ID_WIDTH-1:0]       r_id;

  logic                      r_valid;
  logic                      r_opc;
  logic [31:0]               r_rdata;

  assign w_gnt     = per_slave_req_i && (r_state == IDLE);
  assign w_done    = (r_state == ACCESS) && pready_i;
  assign w_timeout = (r_state == ACCESS) && !pready_i && w_expired;

`ifdef FC_PER2APB_TIMEOUT_EN
  fc_per2apb_tmo_cnt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_tmo_cnt (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .i_clear   (r_state != ACCESS),
    .i_enable  (r_state == ACCESS),
    .o_expired (w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (per_slave_req_i) w_state_nxt = SETUP;
      SETUP:   w_state_nxt = ACCESS;
      ACCESS:  if (w_done || w_timeout) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // psel/penable decode straight from the state so an async reset drops them at once.
  always_comb begin
    w_psel    = 1'b0;
    w_penable = 1'b0;
    case (r_state)
      SETUP:   w_psel = 1'b1;
      ACCESS: begin
        w_psel    = 1'b1;
        w_penable = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_be    <= '0;
      r_id    <= '0;
    end else if (w_gnt) begin
      r_addr  <= per_slave_add_i[APB_ADDR_WIDTH-1:0];
      r_we    <= per_slave_we_i;
      r_wdata <= per_slave_wdata_i;
      r_be    <= per_slave_be_i;
      r_id    <= per_slave_id_i;
    end
  end

  // The ID latch only changes on a grant edge, so it still holds the old ID during r_valid.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_opc   <= RESP_OK;
      r_rdata <= '0;
    end else begin
      r_valid <= 1'b0;
      if (w_done) begin
        r_valid <= 1'b1;
        r_opc   <= pslverr_i;
        r_rdata <= r_we ? 32'h0 : prdata_i;
      end else if (w_timeout) begin
        r_valid <= 1'b1;
        r_opc   <= RESP_ERR;
        r_rdata <= 32'h0;
      end
    end
  end

  assign per_slave_gnt_o     = w_gnt;
  assign per_slave_r_valid_o = r_valid;
  assign per_slave_r_opc_o   = r_opc;
  assign per_slave_r_id_o    = r_id;
  assign per_slave_r_rdata_o = r_rdata;

  assign paddr_o   = r_addr;
  assign pwdata_o  = r_wdata;
  assign pwrite_o  = r_we;
  assign pstrb_o   = r_we ? r_be : 4'b0000;
  assign psel_o    = w_psel;
  assign penable_o = w_penable;

endmodule

// File: tb/tb_fc_per2apb.sv
// Bench for fc_per2apb: vector table, APB slave model and response scoreboard.
module tb_fc_per2apb;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic [31:0] add;
  logic        we;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [7:0]  id;
  logic        gnt;
  logic        rvalid;
  logic        ropc;
  logic [7:0]  rid;
  logic [31:0] rdata;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        pwrite;
  logic [3:0]  pstrb;
  logic        psel;
  logic        penable;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  fc_per2apb #(
    .PER_ADDR_WIDTH (32),
    .APB_ADDR_WIDTH (32),
    .ID_WIDTH       (8),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .per_slave_req_i     (req),
    .per_slave_add_i     (add),
    .per_slave_we_i      (we),
    .per_slave_wdata_i   (wdata),
    .per_slave_be_i      (be),
    .per_slave_id_i      (id),
    .per_slave_gnt_o     (gnt),
    .per_slave_r_valid_o (rvalid),
    .per_slave_r_opc_o   (ropc),
    .per_slave_r_id_o    (rid),
    .per_slave_r_rdata_o (rdata),
    .paddr_o             (paddr),
    .pwdata_o            (pwdata),
    .pwrite_o            (pwrite),
    .pstrb_o             (pstrb),
    .psel_o              (psel),
    .penable_o           (penable),
    .prdata_i            (prdata),
    .pready_i            (pready),
    .pslverr_i           (pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] add;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [7:0]  id;
    logic [31:0] prdata;
    logic        err;
    int          wait_cyc;
    logic [31:0] exp_rdata;
    logic        exp_opc;
    logic [3:0]  exp_pstrb;
    int          exp_lat;
    int          exp_psel;
    int          exp_pen;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        opc;
    logic [7:0]  id;
    int          lat;
    int          gcyc;
  } sb_t;

  sb_t         sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          n_psel  = 0;
  int          n_pen   = 0;
  int          n_rvalid = 0;

  int          slv_wait   = 0;
  logic [31:0] slv_prdata = '0;
  logic        slv_err    = 1'b0;
  int          acc_k      = 0;

  logic [31:0] exp_paddr  = '0;
  logic [31:0] exp_pwdata = '0;
  logic        exp_pwrite = 1'b0;
  logic [3:0]  exp_pstrb  = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // APB slave: stalls slv_wait ACCESS cycles, junk prdata until ready.
  always @(negedge clk) begin
    if (rst_n && psel && penable) begin
      pready  = (acc_k == slv_wait);
      prdata  = pready ? slv_prdata : (32'hBAD0_0000 | 32'(acc_k));
      pslverr = pready ? slv_err : 1'b0;
      acc_k++;
    end else begin
      pready  = 1'b0;
      prdata  = 32'hDEAD_BEEF;
      pslverr = 1'b0;
      acc_k   = 0;
    end
  end

  // APB bus stability and phase counting.
  always @(negedge clk) begin
    if (rst_n && psel) begin
      n_psel++;
      if (penable) n_pen++;
      chk("paddr",  {32'h0, paddr},  {32'h0, exp_paddr});
      chk("pwdata", {32'h0, pwdata}, {32'h0, exp_pwdata});
      chk("pwrite", {63'h0, pwrite}, {63'h0, exp_pwrite});
      chk("pstrb",  {60'h0, pstrb},  {60'h0, exp_pstrb});
    end
  end

  // Response scoreboard.
  always @(negedge clk) begin
    if (rst_n && rvalid) begin
      n_rvalid++;
      if (sb.size() == 0) begin
        chk("unexpected_rvalid", 64'd1, 64'd0);
      end else begin
        sb_t e;
        e = sb.pop_front();
        chk("r_rdata", {32'h0, rdata}, {32'h0, e.rdata});
        chk("r_opc",   {63'h0, ropc},  {63'h0, e.opc});
        chk("r_id",    {56'h0, rid},   {56'h0, e.id});
        chk("r_lat",   64'(cyc - e.gcyc), 64'(e.lat));
      end
    end
  end

  task automatic chk_reset_outs(input string name);
    chk({name, "_ctl"}, {52'h0, gnt, psel, penable, pwrite, pstrb, rvalid, ropc},
        64'h0);
    chk({name, "_rid"},   {56'h0, rid},   64'h0);
    chk({name, "_paddr"}, {paddr, pwdata}, 64'h0);
    chk({name, "_rdata"}, {32'h0, rdata}, 64'h0);
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 60; i++) begin
      @(negedge clk);
      #2;
      if (sb.size() == 0) break;
    end
    if (sb.size() != 0) begin
      chk("resp_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  task automatic issue(input vec_t v);
    logic got;
    got        = 1'b0;
    slv_wait   = v.wait_cyc;
    slv_prdata = v.prdata;
    slv_err    = v.err;
    req   = 1'b1;
    we    = v.we;
    add   = v.add;
    wdata = v.wdata;
    be    = v.be;
    id    = v.id;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (gnt) begin
        got = 1'b1;
        sb.push_back('{v.exp_rdata, v.exp_opc, v.id, v.exp_lat, cyc});
        exp_paddr  = v.add;
        exp_pwdata = v.wdata;
        exp_pwrite = v.we;
        exp_pstrb  = v.exp_pstrb;
        break;
      end
      @(negedge clk);
    end
    chk("gnt", {63'h0, got}, 64'd1);
    @(negedge clk);
    req   = 1'b0;
    add   = $urandom;
    wdata = $urandom;
    be    = 4'($urandom);
    id    = 8'($urandom);
    we    = ~we;
  endtask

  task automatic run_vec(input string name, input vec_t v);
    n_psel = 0;
    n_pen  = 0;
    issue(v);
    wait_idle();
    chk({name, "_psel_cycles"},    64'(n_psel), 64'(v.exp_psel));
    chk({name, "_penable_cycles"}, 64'(n_pen),  64'(v.exp_pen));
  endtask

  vec_t vt[5];
  vec_t v;

  initial begin
    logic [7:0] ids[3];
    int         k;
    int         lastg;
    int         rv_before;

    // we, add, wdata, be, id, prdata, err, wait | rdata, opc, pstrb, lat, psel, pen
    vt[0] = '{1'b0, 32'h1A10_0004, 32'h0000_0000, 4'b1111, 8'h5A, 32'hCAFE_F00D, 1'b0, 0,
              32'hCAFE_F00D, 1'b0, 4'b0000, 3, 2, 1};
    vt[1] = '{1'b1, 32'h1A10_0010, 32'h1234_5678, 4'b0011, 8'h11, 32'h7777_7777, 1'b0, 4,
              32'h0000_0000, 1'b0, 4'b0011, 7, 6, 5};
    vt[2] = '{1'b0, 32'h1A10_0020, 32'h0000_0000, 4'b0101, 8'h77, 32'h55AA_55AA, 1'b1, 1,
              32'h55AA_55AA, 1'b1, 4'b0000, 4, 3, 2};
    vt[3] = '{1'b1, 32'h0000_FFFC, 32'hA5A5_0F0F, 4'b1111, 8'hC3, 32'h9999_9999, 1'b1, 2,
              32'h0000_0000, 1'b1, 4'b1111, 5, 4, 3};
    vt[4] = '{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 4'b1000, 8'hFF, 32'h0BAD_CAFE, 1'b0, 3,
              32'h0BAD_CAFE, 1'b0, 4'b0000, 6, 5, 4};

    rst_n = 1'b0;
    req   = 1'b0;
    add   = '0;
    we    = 1'b0;
    wdata = '0;
    be    = '0;
    id    = '0;
    repeat (3) @(negedge clk);
    chk_reset_outs("reset");
    rst_n = 1'b1;

    // Idle with no request: nothing happens.
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("idle_no_gnt", {62'h0, gnt, psel}, 64'h0);
    end

    for (int i = 0; i < 5; i++) run_vec($sformatf("vec%0d", i), vt[i]);

    // Request held for three back-to-back reads.
    ids   = '{8'hA1, 8'hA2, 8'hA3};
    k     = 0;
    lastg = 0;
    slv_wait = 0;
    slv_err  = 1'b0;
    req   = 1'b1;
    we    = 1'b0;
    wdata = 32'h0;
    be    = 4'hF;
    add   = 32'h2000_0000;
    id    = ids[0];
    for (int i = 0; i < 30 && k < 3; i++) begin
      #1;
      if (gnt) begin
        if (k > 0) begin
          chk("b2b_period",   64'(cyc - lastg), 64'd3);
          chk("b2b_coincide", {63'h0, rvalid},  64'd1);
        end
        lastg      = cyc;
        slv_prdata = 32'hB2B0_0000 + 32'(ids[k]);
        sb.push_back('{32'hB2B0_0000 + 32'(ids[k]), 1'b0, ids[k], 3, cyc});
        exp_paddr  = add;
        exp_pwdata = 32'h0;
        exp_pwrite = 1'b0;
        exp_pstrb  = 4'h0;
        k++;
        @(negedge clk);
        if (k < 3) begin
          id  = ids[k];
          add = 32'h2000_0000 + 32'(k * 4);
        end else begin
          req = 1'b0;
        end
      end else begin
        @(negedge clk);
      end
    end
    chk("b2b_grants", 64'(k), 64'd3);
    wait_idle();

    // Reset asserted during ACCESS.
    v = vt[0];
    v.id = 8'h3C;
    v.wait_cyc = 10;
    issue(v);
    for (int i = 0; i < 10; i++) begin
      if (penable) break;
      @(negedge clk);
    end
    chk("mid_in_access", {63'h0, penable}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_async_drop", {62'h0, psel, penable}, 64'h0);
    sb.delete();
    rv_before = n_rvalid;
    @(negedge clk);
    chk_reset_outs("mid_reset");
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("mid_no_rvalid", 64'(n_rvalid), 64'(rv_before));
    run_vec("post_reset", vt[0]);

`ifdef FC_PER2APB_TIMEOUT_EN
    // Watchdog: no ready ever, then ready on the last allowed cycle.
    v = vt[0];
    v.id = 8'h81;
    v.wait_cyc = 100;
    v.exp_rdata = 32'h0;
    v.exp_opc = 1'b1;
    v.exp_lat = 10;
    v.exp_psel = 9;
    v.exp_pen = 8;
    run_vec("tmo_abort", v);
    v = vt[0];
    v.id = 8'h82;
    v.wait_cyc = 7;
    v.exp_lat = 10;
    v.exp_psel = 9;
    v.exp_pen = 8;
    run_vec("tmo_edge_ready", v);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
